gcd_job_scheduler: RTL and testbench
====================================

// Module: gcd_job_scheduler
// PURPOSE
//  Shares one subtractive GCD engine (gcd datapath + controller pair) among N_REQ requesters.
//  Round-robin arbitration; captures the winner's operands and sequences the engine's start/serial-load protocol.
//  Waits for done, returns result with a one-cycle ack to the winner.
//  Sits between client blocks and the single GCD engine instance.
// PARAMETERS
//  N_REQ     4     number of requesters (2..8)
//  WIDTH     16    operand/result width (matches engine data_in)
//  MAX_WAIT  1023  WAIT-state cycle limit before abort
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            asynchronous, active-high reset
//  req         in   N_REQ        level request; held until ack
//  op_a        in   N_REQ*WIDTH  operand A, slice i = op_a[i*WIDTH +: WIDTH]
//  op_b        in   N_REQ*WIDTH  operand B, same packing
//  ack         out  N_REQ        one-hot, one-cycle pulse: result valid for that requester
//  err         out  N_REQ        pulses with ack on timeout abort
//  result      out  WIDTH        GCD result, valid while ack!=0
//  busy        out  1            state != IDLE
//  gcd_start   out  1            engine start, one-cycle pulse
//  gcd_data    out  WIDTH        engine data_in bus
//  gcd_done    in   1            engine done (level)
//  gcd_result  in   WIDTH        engine A-register output
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, ack=0, err=0, result=0, gcd_start=0, gcd_data=0, busy=0, timeout count=0.
//  Reset mid-operation aborts the in-flight job; no ack is issued.
//  FSM: IDLE -> LOAD_A -> LOAD_B -> WAIT -> RESP -> IDLE; zero-operand bypass IDLE -> RESP.
//  IDLE: search req from ptr upward, wrapping mod N_REQ; first set bit wins.
//   Register the winner index and its op_a/op_b.
//   Either operand 0: go RESP, result = A|B (gcd(0,x)=x; gcd(0,0)=0). Otherwise go LOAD_A.
//  LOAD_A: gcd_start=1, gcd_data=A (one cycle only).
//  LOAD_B: gcd_start=0, gcd_data=B; clear timeout counter.
//  WAIT: gcd_data holds B; counter increments each cycle.
//   gcd_done=1 -> result<=gcd_result, go RESP.
//   Counter reaches MAX_WAIT with no done -> result<=0, set err flag, go RESP.
//   Done has priority if both occur in the same cycle.
//  RESP (1 cycle): ack[winner]=1, err[winner]=abort flag; ptr<=(winner+1) mod N_REQ; go IDLE.
//  gcd_done is ignored outside WAIT. Engine guarantees done low within 1 cycle of start.
//  Operands are captured at grant. Later changes to op_a/op_b or a dropped req do not affect the job; ack still pulses.
//  Served requester's req is masked during the first IDLE cycle after RESP; requester drops req after seeing ack.
//  Latency, req seen in IDLE to ack:
//   normal job: 3 + (WAIT cycles to done) + 1;
//   zero operand: 2 cycles; timeout: 3 + MAX_WAIT + 1.
//  Only one job in flight. No other requester is granted until RESP completes.
//  result holds its value after RESP; only ack qualifies it.
// TESTING
//  1 req[0], A=143, B=78, engine model -> gcd_start 1 cycle, gcd_data 143 then 78; ack[0] pulse, result=13, err=0.
//  2 req=4'b1111 after reset, all distinct operands -> acks in order 0,1,2,3.
//    Then req[3]|req[0] -> 0 served before 3.
//  3 op_a=0, op_b=25 -> no gcd_start, ack 2 cycles after req, result=25.
//    op_a=op_b=0 -> result=0, err=0.
//  4 MAX_WAIT=16, engine never asserts done -> ack+err on requester 16 cycles after WAIT entry, result=0.
//    Next request served normally.
//  5 rst pulsed during WAIT -> all outputs 0 asynchronously, no ack.
//    After release, req[2] with 36/24 -> result=12, ptr restarted at 0.
//  6 gcd_done forced high during IDLE/LOAD_A/LOAD_B, A=7, B=7 -> ignored; ack only after done seen in WAIT, result=7.

Source files
------------

// File: rtl/gcd_job_scheduler.sv
// Round-robin front end that shares one subtractive GCD engine among N_REQ requesters.
// Captures the winner's operands, drives the engine's start/serial-load protocol and returns the result.
module gcd_job_scheduler #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_WAIT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       err,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic                   gcd_start,
  output logic [WIDTH-1:0]       gcd_data,
  input  logic                   gcd_done,
  input  logic [WIDTH-1:0]       gcd_result
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   winner_q, winner_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              abort_q, abort_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]  mask_q, mask_d;

  logic [N_REQ-1:0]  req_eff;
  logic              grant_valid;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW-1:0]   cand_idx;
  int unsigned       cand;
  logic [WIDTH-1:0]  grant_a;
  logic [WIDTH-1:0]  grant_b;
  logic [N_REQ-1:0]  winner_oh;

  // The requester just served is hidden for one IDLE cycle so a late-dropping req is not regranted.
  assign req_eff = req & ~mask_q;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand     = (32'(ptr_q) + i) % N_REQ;
      cand_idx = IdxW'(cand);
      if (!grant_valid && req_eff[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign grant_a   = op_a[grant_idx*WIDTH +: WIDTH];
  assign grant_b   = op_b[grant_idx*WIDTH +: WIDTH];
  assign winner_oh = N_REQ'(1) << winner_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    abort_d  = abort_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    unique case (state_q)
      StIdle: begin
        mask_d = '0;
        if (grant_valid) begin
          winner_d = grant_idx;
          a_d      = grant_a;
          b_d      = grant_b;
          abort_d  = 1'b0;
          // gcd(0,x) = x, so a zero operand never needs the engine.
          if (grant_a == '0 || grant_b == '0) begin
            result_d = grant_a | grant_b;
            state_d  = StResp;
          end else begin
            state_d = StLoadA;
          end
        end
      end
      StLoadA: begin
        state_d = StLoadB;
      end
      StLoadB: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (gcd_done) begin
          result_d = gcd_result;
          state_d  = StResp;
        end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
          result_d = '0;
          abort_d  = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        mask_d  = winner_oh;
        ptr_d   = (winner_q == IdxW'(N_REQ - 1)) ? '0 : winner_q + IdxW'(1);
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      winner_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      abort_q  <= 1'b0;
      cnt_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      abort_q  <= abort_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    gcd_data = '0;
    unique case (state_q)
      StLoadA:        gcd_data = a_q;
      StLoadB, StWait: gcd_data = b_q;
      default:        gcd_data = '0;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign gcd_start = (state_q == StLoadA);
  assign ack       = (state_q == StResp) ? winner_oh : '0;
  assign err       = (state_q == StResp && abort_q) ? winner_oh : '0;
  assign result    = result_q;

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Directed bench for gcd_job_scheduler with a behavioural GCD engine model.
// Covers arbitration order, zero bypass, timeout abort, async reset and done masking.
module tb_gcd_job_scheduler;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic [W-1:0]   result;
  logic           busy;
  logic           gcd_start;
  logic [W-1:0]   gcd_data;
  logic           gcd_done;
  logic [W-1:0]   gcd_result;

  int n_checks = 0;
  int n_fail   = 0;

  gcd_job_scheduler #(
    .N_REQ   (N),
    .WIDTH   (W),
    .MAX_WAIT(MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .ack       (ack),
    .err       (err),
    .result    (result),
    .busy      (busy),
    .gcd_start (gcd_start),
    .gcd_data  (gcd_data),
    .gcd_done  (gcd_done),
    .gcd_result(gcd_result)
  );

  always #5 clk = ~clk;

  // Engine model: A on the start cycle, B on the next, done a few cycles later.
  logic [W-1:0] m_a, m_b, m_res;
  logic         m_done;
  int           m_phase, m_cnt;
  logic         hang = 1'b0;
  logic         force_done = 1'b0;

  assign gcd_done   = m_done | force_done;
  assign gcd_result = m_res;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p, q;
    p = x;
    q = y;
    for (int k = 0; k < 70000 && p != q; k++) begin
      if (p > q) p = p - q;
      else q = q - p;
    end
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done  <= 1'b0;
      m_phase <= 0;
      m_cnt   <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_res   <= 16'h00AA;
    end else if (gcd_start) begin
      m_a     <= gcd_data;
      m_done  <= 1'b0;
      m_phase <= 1;
    end else if (m_phase == 1) begin
      m_b     <= gcd_data;
      m_phase <= 2;
      m_cnt   <= 0;
    end else if (m_phase == 2 && !hang) begin
      if (m_cnt == 3) begin
        m_res   <= ref_gcd(m_a, m_b);
        m_done  <= 1'b1;
        m_phase <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  // Polls on negedges until ack; records start pulses and the A/B data sequence.
  task automatic wait_ack(input int max_cyc, output logic [N-1:0] a_seen,
                          output logic [W-1:0] res, output logic [N-1:0] e_seen,
                          output int cyc, output int starts,
                          output logic [W-1:0] da, output logic [W-1:0] db);
    logic got, prev;
    got = 1'b0; prev = 1'b0; starts = 0; cyc = 0;
    a_seen = '0; e_seen = '0; res = '0; da = '0; db = '0;
    for (int c = 1; c <= max_cyc && !got; c++) begin
      @(negedge clk);
      if (gcd_start) begin
        starts++;
        da   = gcd_data;
        prev = 1'b1;
      end else if (prev) begin
        db   = gcd_data;
        prev = 1'b0;
      end
      if (ack != '0) begin
        got    = 1'b1;
        a_seen = ack;
        e_seen = err;
        res    = result;
        cyc    = c;
      end
    end
    check("ack_seen", 32'(got), 1);
    req = req & ~a_seen;
    @(negedge clk);
    check("ack_one_cycle", 32'(ack), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [N-1:0] a_s, e_s;
  logic [W-1:0] r_s, da_s, db_s;
  int           cyc_s, st_s;
  logic [W-1:0] exp_r[4];

  initial begin
    rst  = 1'b1;
    req  = '0;
    op_a = '0;
    op_b = '0;
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_result", 32'(result), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(gcd_start), 0);
    check("rst_data", 32'(gcd_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic job through the engine.
    set_ops(0, 143, 78);
    req = 4'b0001;
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t1_starts", 32'(st_s), 1);
    check("t1_data_a", 32'(da_s), 143);
    check("t1_data_b", 32'(db_s), 78);
    check("t1_ack", 32'(a_s), 1);
    check("t1_result", 32'(r_s), 13);
    check("t1_err", 32'(e_s), 0);

    // Round-robin from a fresh pointer.
    do_reset();
    set_ops(0, 12, 18);  exp_r[0] = 6;
    set_ops(1, 35, 21);  exp_r[1] = 7;
    set_ops(2, 100, 75); exp_r[2] = 25;
    set_ops(3, 17, 51);  exp_r[3] = 17;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
      check("t2_order", 32'(a_s), 32'(1) << k);
      check("t2_result", 32'(r_s), 32'(exp_r[k]));
    end
    req = 4'b1001;
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t2_wrap_first", 32'(a_s), 32'h1);
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t2_wrap_second", 32'(a_s), 32'h8);

    // Zero-operand bypass.
    set_ops(1, 0, 25);
    req = 4'b0010;
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t3_latency", 32'(cyc_s), 1);
    check("t3_starts", 32'(st_s), 0);
    check("t3_ack", 32'(a_s), 32'h2);
    check("t3_result", 32'(r_s), 25);
    set_ops(1, 0, 0);
    req = 4'b0010;
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t3_zz_result", 32'(r_s), 0);
    check("t3_zz_err", 32'(e_s), 0);

    // Timeout abort, then a normal job.
    hang = 1'b1;
    set_ops(0, 5, 3);
    req = 4'b0001;
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t4_ack", 32'(a_s), 32'h1);
    check("t4_err", 32'(e_s), 32'h1);
    check("t4_result", 32'(r_s), 0);
    check("t4_latency", 32'(cyc_s), 3 + MW);
    hang = 1'b0;
    set_ops(2, 48, 18);
    req = 4'b0100;
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t4_next_ack", 32'(a_s), 32'h4);
    check("t4_next_err", 32'(e_s), 0);
    check("t4_next_result", 32'(r_s), 6);

    // Move pointer to 2, then reset during WAIT.
    set_ops(1, 10, 4);
    req = 4'b0010;
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t5_pre_result", 32'(r_s), 2);
    hang = 1'b1;
    set_ops(0, 8, 12);
    req = 4'b0001;
    repeat (8) @(negedge clk);
    check("t5_busy_wait", 32'(busy), 1);
    check("t5_data_holds_b", 32'(gcd_data), 12);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ack", 32'(ack), 0);
    check("t5_rst_err", 32'(err), 0);
    check("t5_rst_result", 32'(result), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_start", 32'(gcd_start), 0);
    check("t5_rst_data", 32'(gcd_data), 0);
    repeat (2) begin
      @(negedge clk);
      check("t5_no_ack", 32'(ack), 0);
    end
    rst  = 1'b0;
    hang = 1'b0;
    set_ops(1, 9, 6);
    set_ops(2, 36, 24);
    req = 4'b0110;
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t5_ptr_restart", 32'(a_s), 32'h2);
    check("t5_r1", 32'(r_s), 3);
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t5_ack2", 32'(a_s), 32'h4);
    check("t5_r2", 32'(r_s), 12);

    // done forced high outside WAIT must be ignored.
    force_done = 1'b1;
    set_ops(3, 7, 7);
    req = 4'b1000;
    repeat (3) begin
      @(negedge clk);
      check("t6_no_early_ack", 32'(ack), 0);
    end
    force_done = 1'b0;
    check("t6_busy", 32'(busy), 1);
    wait_ack(100, a_s, r_s, e_s, cyc_s, st_s, da_s, db_s);
    check("t6_ack", 32'(a_s), 32'h8);
    check("t6_result", 32'(r_s), 7);
    check("t6_err", 32'(e_s), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
